// File: rtl/tug_round_scorer.sv
// Tug-of-war match controller: round-win detection, per-side scores,
// score digits, round-restart strobe and match-end flag.
module tug_round_scorer #(
    parameter int SCORE_MAX   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             led_l,
    input  logic             led_r,
    input  logic             key_l,
    input  logic             key_r,
    output logic             round_res,
    output logic [CNT_W-1:0] score_l,
    output logic [CNT_W-1:0] score_r,
    output logic [6:0]       hex_l,
    output logic [6:0]       hex_r,
    output logic             match_over,
    output logic             winner_l
);

    localparam logic [1:0] PLAY    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] RESTART = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SMAX      = CNT_W'(SCORE_MAX);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [HC_W-1:0]  hold_cnt;
    logic [HC_W-1:0]  hold_n;
    logic [CNT_W-1:0] score_l_n;
    logic [CNT_W-1:0] score_r_n;
    logic             winner_n;
    logic             win_l;
    logic             win_r;

    // A round is won by pressing while your own edge light is lit
    assign win_l = led_l & key_l;
    assign win_r = led_r & key_r;

    // Active-low 7-segment digit, gfedcba; out-of-range values blank
    function automatic logic [6:0] seg7(input logic [CNT_W-1:0] v);
        logic [6:0] s;
        s = 7'b1111111;
        if (v <= CNT_W'(7)) begin
            unique case (3'(v))
                3'd0: s = 7'b1000000;
                3'd1: s = 7'b1111001;
                3'd2: s = 7'b0100100;
                3'd3: s = 7'b0110000;
                3'd4: s = 7'b0011001;
                3'd5: s = 7'b0010010;
                3'd6: s = 7'b0000010;
                3'd7: s = 7'b1111000;
                default: s = 7'b1111111;
            endcase
        end
        return s;
    endfunction

    // Next-state and score update; inputs only matter while in PLAY
    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        score_l_n = score_l;
        score_r_n = score_r;
        winner_n  = winner_l;
        unique case (state)
            PLAY: begin
                if (win_l && !win_r) begin
                    score_l_n = score_l + 1'b1;
                    if (score_l_n == SMAX) begin
                        state_n  = DONE;
                        winner_n = 1'b1;
                    end else begin
                        state_n = HOLD;
                        hold_n  = HOLD_LOAD;
                    end
                end else if (win_r && !win_l) begin
                    score_r_n = score_r + 1'b1;
                    if (score_r_n == SMAX) begin
                        state_n  = DONE;
                        winner_n = 1'b0;
                    end else begin
                        state_n = HOLD;
                        hold_n  = HOLD_LOAD;
                    end
                end else if (win_l && win_r) begin
                    // Simultaneous win is a tie: replay the round
                    state_n = HOLD;
                    hold_n  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = RESTART;
                end else begin
                    hold_n = hold_cnt - 1'b1;
                end
            end
            RESTART: begin
                state_n = PLAY;
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = PLAY;
            end
        endcase
    end

    // State, counters and registered outputs; reset holds the playfield in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PLAY;
            hold_cnt   <= '0;
            score_l    <= '0;
            score_r    <= '0;
            winner_l   <= 1'b0;
            match_over <= 1'b0;
            round_res  <= 1'b1;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            score_l    <= score_l_n;
            score_r    <= score_r_n;
            winner_l   <= winner_n;
            match_over <= (state_n == DONE);
            round_res  <= (state_n == RESTART) || (state_n == DONE);
        end
    end

    // Score digits decoded from the registered scores
    always_comb begin
        hex_l = seg7(score_l);
        hex_r = seg7(score_r);
    end

endmodule

// File: tb/tb_tug_round_scorer.sv
// Directed bench for tug_round_scorer: reset, wins, ties, holds,
// match end and asynchronous reset abort.
module tb_tug_round_scorer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       led_l = 1'b0;
    logic       led_r = 1'b0;
    logic       key_l = 1'b0;
    logic       key_r = 1'b0;
    logic       round_res;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic [6:0] hex_l;
    logic [6:0] hex_r;
    logic       match_over;
    logic       winner_l;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;
    localparam logic [6:0] H7 = 7'b1111000;

    tug_round_scorer #(
        .SCORE_MAX(7),
        .HOLD_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .led_l(led_l),
        .led_r(led_r),
        .key_l(key_l),
        .key_r(key_r),
        .round_res(round_res),
        .score_l(score_l),
        .score_r(score_r),
        .hex_l(hex_l),
        .hex_r(hex_r),
        .match_over(match_over),
        .winner_l(winner_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present inputs for one edge, then clear them
    task automatic drive(input logic ll, input logic kl,
                         input logic lr, input logic kr);
        led_l = ll; key_l = kl; led_r = lr; key_r = kr;
        tick();
        led_l = 0; key_l = 0; led_r = 0; key_r = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (score_l !== 3'd0 || score_r !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_scores got %0d/%0d exp 0/0", score_l, score_r);
        end
        n_checks++;
        if (hex_l !== H0 || hex_r !== H0) begin
            n_fail++;
            $display("FAIL rst_hex got %b/%b exp %b", hex_l, hex_r, H0);
        end
        n_checks++;
        if (match_over !== 1'b0 || winner_l !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_match got %b/%b exp 0/0", match_over, winner_l);
        end
        reset = 1'b1;
        n_checks++;
        if (round_res !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rr_first got %b exp 1", round_res);
        end
        tick();
        n_checks++;
        if (round_res !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rr_after got %b exp 0", round_res);
        end
    endtask

    task automatic test_left_win();
        drive(1, 1, 0, 0);
        n_checks++;
        if (score_l !== 3'd1 || hex_l !== H1) begin
            n_fail++;
            $display("FAIL t2_score got %0d/%b exp 1/%b", score_l, hex_l, H1);
        end
        n_checks++;
        if (score_r !== 3'd0) begin
            n_fail++;
            $display("FAIL t2_score_r got %0d exp 0", score_r);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (round_res !== 1'b0) begin
                n_fail++;
                $display("FAIL t2_hold_rr%0d got %b exp 0", i, round_res);
            end
            if (i < 3) tick();
        end
        tick();
        n_checks++;
        if (round_res !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_strobe got %b exp 1", round_res);
        end
        tick();
        n_checks++;
        if (round_res !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_strobe_end got %b exp 0", round_res);
        end
    endtask

    task automatic test_ignored();
        drive(0, 1, 0, 0);
        n_checks++;
        if (score_l !== 3'd1 || round_res !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_nolight got %0d/%b exp 1/0", score_l, round_res);
        end
        // Still in PLAY: an immediate valid win scores
        drive(1, 1, 0, 0);
        n_checks++;
        if (score_l !== 3'd2 || hex_l !== H2) begin
            n_fail++;
            $display("FAIL t3_win got %0d/%b exp 2/%b", score_l, hex_l, H2);
        end
        drive(1, 1, 1, 1);
        n_checks++;
        if (score_l !== 3'd2 || score_r !== 3'd0) begin
            n_fail++;
            $display("FAIL t3_in_hold got %0d/%0d exp 2/0", score_l, score_r);
        end
        tick();
        tick();
        n_checks++;
        if (round_res !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_pre_strobe got %b exp 0", round_res);
        end
        tick();
        n_checks++;
        if (round_res !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_strobe got %b exp 1", round_res);
        end
        tick();
    endtask

    task automatic test_tie();
        drive(1, 1, 1, 1);
        n_checks++;
        if (score_l !== 3'd2 || score_r !== 3'd0) begin
            n_fail++;
            $display("FAIL t4_tie got %0d/%0d exp 2/0", score_l, score_r);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (round_res !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_hold got %b exp 0", round_res);
        end
        tick();
        n_checks++;
        if (round_res !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_strobe got %b exp 1", round_res);
        end
        tick();
        n_checks++;
        if (round_res !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_strobe_end got %b exp 0", round_res);
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1, 1, 0, 0);
        n_checks++;
        if (score_l !== 3'd3 || hex_l !== H3) begin
            n_fail++;
            $display("FAIL t6_pre got %0d/%b exp 3/%b", score_l, hex_l, H3);
        end
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (score_l !== 3'd0 || hex_l !== H0) begin
            n_fail++;
            $display("FAIL t6_async got %0d/%b exp 0/%b", score_l, hex_l, H0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (round_res !== 1'b0 || score_l !== 3'd0) begin
                n_fail++;
                $display("FAIL t6_no_pulse%0d got %b/%0d exp 0/0",
                         i, round_res, score_l);
            end
            tick();
        end
    endtask

    task automatic test_match_end();
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 1, 1);
            n_checks++;
            if (score_r !== 3'(k) || match_over !== 1'b0) begin
                n_fail++;
                $display("FAIL t5_win%0d got %0d/%b exp %0d/0",
                         k, score_r, match_over, k);
            end
            repeat (5) tick();
        end
        drive(0, 0, 1, 1);
        n_checks++;
        if (score_r !== 3'd7 || hex_r !== H7) begin
            n_fail++;
            $display("FAIL t5_final got %0d/%b exp 7/%b", score_r, hex_r, H7);
        end
        n_checks++;
        if (match_over !== 1'b1 || winner_l !== 1'b0 || round_res !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_done got mo=%b wl=%b rr=%b exp 1/0/1",
                     match_over, winner_l, round_res);
        end
        drive(0, 0, 1, 1);
        drive(1, 1, 0, 0);
        repeat (6) tick();
        n_checks++;
        if (score_r !== 3'd7 || score_l !== 3'd0 || round_res !== 1'b1
            || match_over !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_frozen got %0d/%0d rr=%b mo=%b exp 0/7 1 1",
                     score_l, score_r, round_res, match_over);
        end
    endtask

    task automatic test_left_match();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) begin
            drive(1, 1, 0, 0);
            if (k < 7) repeat (5) tick();
        end
        n_checks++;
        if (score_l !== 3'd7 || match_over !== 1'b1 || winner_l !== 1'b1) begin
            n_fail++;
            $display("FAIL left_match got %0d mo=%b wl=%b exp 7 1 1",
                     score_l, match_over, winner_l);
        end
    endtask

    initial begin
        test_reset();
        test_left_win();
        test_ignored();
        test_tie();
        test_reset_in_hold();
        test_match_end();
        test_left_match();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
